// File: rtl/eth_pkt_lib.sv
// Shared types and constants for the eth_pkt_if stream family.
package eth_pkt_lib;

  typedef struct packed {
    int unsigned data_w;
    int unsigned mod_w;
    int unsigned tuser_w;
  } if_props_t;

  localparam if_props_t DEFAULT_PROPERTIES = '{data_w: 32'd64, mod_w: 32'd3, tuser_w: 32'd1};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PASS = 2'd1,
    DROP = 2'd2
  } gate_state_t;

  localparam string GATE_HOLD = "HOLD";
  localparam string GATE_DROP = "DROP";

endpackage

// File: rtl/eth_pkt_if.sv
// Valid/ready packet stream with sop/eop framing and byte-modulo on the last word.
interface eth_pkt_if #(
  parameter eth_pkt_lib::if_props_t PROPS = eth_pkt_lib::DEFAULT_PROPERTIES
);
  logic                     val;
  logic                     ready;
  logic                     sop;
  logic                     eop;
  logic [PROPS.data_w-1:0]  data;
  logic [PROPS.mod_w-1:0]   mod;
  logic [PROPS.tuser_w-1:0] tuser;

  modport i (input val, sop, eop, data, mod, tuser, output ready);
  modport o (output val, sop, eop, data, mod, tuser, input ready);
endinterface

// File: rtl/eth_pkt_sat_cnt.sv
// Saturating event counter with synchronous clear taking priority over increment.
module eth_pkt_sat_cnt #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_d;
  logic [W-1:0] cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/eth_pkt_if_gate.sv
// Packet-boundary-aware stream gate: enable is sampled only at sop, so packets are never cut.
module eth_pkt_if_gate
  import eth_pkt_lib::*;
#(
  parameter if_props_t IF_PROPERTIES = DEFAULT_PROPERTIES,
  parameter string     GATE_MODE     = GATE_DROP,
  parameter int        CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enable_i,
  input  logic             stall_i,
  input  logic             cnt_clr_i,
  eth_pkt_if.i             pkt_i,
  eth_pkt_if.o             pkt_o,
  output logic             in_pkt_o,
  output logic [CNT_W-1:0] pass_cnt_o,
  output logic [CNT_W-1:0] drop_cnt_o,
  output logic [CNT_W-1:0] err_cnt_o
);
  localparam bit HOLD_MODE = (GATE_MODE == GATE_HOLD);

  gate_state_t state_d, state_q;
  logic        in_pkt_d, in_pkt_q;
  logic        out_val_s, in_ready_s;
  logic        pass_inc_s, drop_inc_s, err_inc_s;

  logic [IF_PROPERTIES.data_w-1:0]  data_s;
  logic [IF_PROPERTIES.mod_w-1:0]   mod_s;
  logic [IF_PROPERTIES.tuser_w-1:0] tuser_s;

  assign data_s      = pkt_i.data;
  assign mod_s       = pkt_i.mod;
  assign tuser_s     = pkt_i.tuser;
  assign pkt_o.data  = data_s;
  assign pkt_o.mod   = mod_s;
  assign pkt_o.tuser = tuser_s;
  assign pkt_o.sop   = pkt_i.sop;
  assign pkt_o.eop   = pkt_i.eop;
  assign pkt_o.val   = out_val_s;
  assign pkt_i.ready = in_ready_s;

  // Only the forward/PASS paths let ready follow pkt_o.ready; drop and orphan paths never do.
  always_comb begin
    out_val_s  = 1'b0;
    in_ready_s = 1'b0;
    pass_inc_s = 1'b0;
    drop_inc_s = 1'b0;
    err_inc_s  = 1'b0;
    state_d    = state_q;
    case (state_q)
      IDLE: begin
        if (!pkt_i.val) begin
          state_d = IDLE;
        end else if (!pkt_i.sop) begin
          in_ready_s = 1'b1;
          err_inc_s  = 1'b1;
        end else if (enable_i) begin
          out_val_s  = 1'b1;
          in_ready_s = pkt_o.ready;
          if (pkt_o.ready && pkt_i.eop) begin
            pass_inc_s = 1'b1;
          end else if (pkt_o.ready) begin
            state_d = PASS;
          end else begin
            state_d = IDLE;
          end
        end else if (HOLD_MODE) begin
          state_d = IDLE;
        end else begin
          in_ready_s = 1'b1;
          drop_inc_s = 1'b1;
          state_d    = pkt_i.eop ? IDLE : DROP;
        end
      end
      PASS: begin
        out_val_s  = pkt_i.val;
        in_ready_s = pkt_o.ready;
        if (pkt_i.val && pkt_o.ready && pkt_i.eop) begin
          pass_inc_s = 1'b1;
          state_d    = IDLE;
        end else begin
          state_d = PASS;
        end
      end
      DROP: begin
        in_ready_s = 1'b1;
        if (pkt_i.val && pkt_i.eop) begin
          state_d = IDLE;
        end else begin
          state_d = DROP;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (stall_i) begin
      out_val_s  = 1'b0;
      in_ready_s = 1'b0;
      pass_inc_s = 1'b0;
      drop_inc_s = 1'b0;
      err_inc_s  = 1'b0;
      state_d    = state_q;
    end else begin
      state_d = state_d;
    end
    in_pkt_d = (state_d != IDLE);
  end

  // Packet tracker state and its registered in-packet flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      in_pkt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_pkt_q <= in_pkt_d;
    end
  end

  assign in_pkt_o = in_pkt_q;

  eth_pkt_sat_cnt #(.W(CNT_W)) u_pass_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr_i), .inc_i(pass_inc_s), .cnt_o(pass_cnt_o)
  );
  eth_pkt_sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr_i), .inc_i(drop_inc_s), .cnt_o(drop_cnt_o)
  );
  eth_pkt_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk_i(clk_i), .rst_i(rst_i), .clr_i(cnt_clr_i), .inc_i(err_inc_s), .cnt_o(err_cnt_o)
  );
endmodule
